sar_adc_ctrl: RTL and testbench
===============================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: extra clk cycles each trial code is held before the comparator is sampled; legal range 0..15.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: conversion request, sampled on rising clk.
REQ-005 SHALL have port comp_in, input, 1: comparator output; 1 = analog input >= DAC output for the current dac_code.
REQ-006 SHALL have port dac_code, output, 12: trial code driven to the 12-bit DAC.
REQ-007 SHALL have port result, output, 12: last completed conversion.
REQ-008 SHALL have port valid, output, 1: one-cycle pulse when result updates.
REQ-009 SHALL have port busy, output, 1: high while a conversion is in progress.

Function
REQ-010 SHALL implement an FSM with states IDLE, TRIAL and DECIDE, plus an internal bit index 11..0 and a settle counter.
REQ-011 In IDLE, start=1 at edge k SHALL move to TRIAL: busy=1, dac_code=12'h800, bit index=11, settle counter cleared.
REQ-012 Each trial code SHALL be held for exactly SETTLE_CYCLES+1 cycles; comp_in SHALL be sampled only on the last of these cycles (DECIDE).
REQ-013 In DECIDE, comp_in=1 SHALL keep the current bit and comp_in=0 SHALL clear it; the next lower bit SHALL then be set in the same edge.
REQ-014 After bit 0 is decided, at edge k+12*(SETTLE_CYCLES+1):
- result = final code
- dac_code = final code, held
- valid = 1 for exactly one cycle
- busy = 0
- FSM returns to IDLE.
REQ-015 Conversion latency SHALL be fixed at 12*(SETTLE_CYCLES+1) cycles and SHALL NOT depend on data (24 cycles at the default).
REQ-016 start while busy=1 SHALL be ignored with no queuing; result and the conversion in progress SHALL NOT be affected.
REQ-017 start=1 in the valid cycle SHALL be accepted, giving back-to-back conversions with no dead cycle.
REQ-018 comp_in held at 1 for all decisions SHALL yield 12'hFFF; comp_in held at 0 SHALL yield 12'h000.
REQ-019 result SHALL change only on the valid edge.

Reset
REQ-020 While rst=0 the block SHALL hold: state=IDLE, dac_code=0, result=0, valid=0, busy=0, bit index=11, counters=0, independent of clk.
REQ-021 Reset asserted mid-conversion SHALL abort the conversion; no valid SHALL be generated and the partial code SHALL be discarded.
REQ-022 The first start after rst deasserts SHALL be accepted on the first rising edge at which rst=1.

Configuration
REQ-023 Macro SAR_OVERSAMPLE_EN defined: one accepted start SHALL run 4 consecutive conversions into a 14-bit accumulator.
- result SHALL be accumulator[13:2] (truncating average).
- valid SHALL pulse once, after 48*(SETTLE_CYCLES+1) cycles.
- busy SHALL stay high across all 4 conversions.
- dac_code SHALL restart at 12'h800 for each sub-conversion.
REQ-024 Macro undefined: no accumulator SHALL exist and behaviour SHALL be exactly REQ-010..REQ-019.

Verification
REQ-025 Comparator model (comp_in = vin >= dac_code), vin=12'hA5C, SETTLE_CYCLES=1, start pulse -> dac_code sequence starts 800,C00,A00,B00,A80,...; valid exactly 24 cycles after the start edge; result=12'hA5C.
REQ-026 vin=0 -> result 12'h000; vin=12'hFFF -> result 12'hFFF; vin=12'h800 -> result 12'h800.
REQ-027 Second start 5 cycles into a conversion (vin=12'h123) -> single valid, result 12'h123, busy never drops early.
REQ-028 rst=0 at cycle 10 of a conversion -> all outputs 0 asynchronously, no valid; after release, start with vin=12'h3C7 -> result 12'h3C7.
REQ-029 start held high continuously, vin stepping 12'h100 -> 12'h200 between conversions -> valid every 24 cycles, results 12'h100 then 12'h200.
REQ-030 SAR_OVERSAMPLE_EN defined, vin alternating 12'h100/12'h104 per sub-conversion -> single valid after 96 cycles, result 12'h102.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
`timescale 1ns/1ps
// sar_adc_ctrl
// Successive-approximation ADC controller for a 12-bit DAC + comparator.
// A conversion walks the bits MSB to LSB. Each trial code is held for
// SETTLE_CYCLES+1 clocks, and the comparator is sampled on the last of them.
// Latency is fixed at 12*(SETTLE_CYCLES+1) clocks from the start edge to
// the valid edge.
//
// Optional feature (macro SAR_OVERSAMPLE_EN): a single start runs 4
// back-to-back sub-conversions. They are summed into a 14-bit accumulator,
// and result is the truncated average acc[13:2].
//
// Handshake: start is a request that is sampled only while idle (busy=0).
// Requests seen while busy are dropped and never queued. valid is a
// one-cycle pulse, and result changes only on that edge. start is also
// accepted in the valid cycle, so conversions can run back to back.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      conversion request
//   comp_in    comparator output (1 = vin >= dac_code)
//   dac_code   trial code to the DAC; holds the final code after completion
//   result     last completed conversion
//   valid      one-cycle pulse when result updates
//   busy       conversion in progress
//   fsm_state  debug view of the FSM state (0 IDLE, 1 TRIAL, 2 DECIDE)
module sar_adc_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        comp_in,
  output logic [11:0] dac_code,
  output logic [11:0] result,
  output logic        valid,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIAL  = 2'd1,
    DECIDE = 2'd2
  } state_t;

  // With zero settle cycles every trial code is decided in its first cycle,
  // so TRIAL is skipped entirely.
  localparam state_t     ENTRY       = (SETTLE_CYCLES == 0) ? DECIDE : TRIAL;
  localparam logic [3:0] LAST_SETTLE = (SETTLE_CYCLES == 0) ? 4'd0
                                                            : 4'(SETTLE_CYCLES - 1);

  state_t      state, state_d;
  logic [11:0] code, code_d;
  logic [11:0] result_q, result_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [3:0]  idx, idx_d;
  logic [3:0]  cnt, cnt_d;
  logic [11:0] decided;

`ifdef SAR_OVERSAMPLE_EN
  logic [1:0]  sub, sub_d;
  logic [13:0] acc, acc_d;
  logic [13:0] acc_sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      code     <= 12'h000;
      result_q <= 12'h000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      idx      <= 4'd11;
      cnt      <= 4'd0;
`ifdef SAR_OVERSAMPLE_EN
      sub      <= 2'd0;
      acc      <= 14'd0;
`endif
    end else begin
      state    <= state_d;
      code     <= code_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
`ifdef SAR_OVERSAMPLE_EN
      sub      <= sub_d;
      acc      <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    code_d   = code;
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    idx_d    = idx;
    cnt_d    = cnt;
    // The current trial code with the bit under test resolved by the comparator.
    decided      = code;
    decided[idx] = comp_in;
`ifdef SAR_OVERSAMPLE_EN
    sub_d   = sub;
    acc_d   = acc;
    acc_sum = acc + {2'b00, decided};
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_d = ENTRY;
          code_d  = 12'h800;
          idx_d   = 4'd11;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
`ifdef SAR_OVERSAMPLE_EN
          sub_d   = 2'd0;
          acc_d   = 14'd0;
`endif
        end
      end

      TRIAL: begin
        if (cnt == LAST_SETTLE) begin
          state_d = DECIDE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt + 4'd1;
        end
      end

      DECIDE: begin
        cnt_d = 4'd0;
        if (idx != 4'd0) begin
          // Resolve this bit and raise the next lower one in the same edge.
          code_d  = decided | (12'h001 << (idx - 4'd1));
          idx_d   = idx - 4'd1;
          state_d = ENTRY;
        end else begin
`ifdef SAR_OVERSAMPLE_EN
          if (sub == 2'd3) begin
            result_d = acc_sum[13:2];
            code_d   = decided;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            idx_d    = 4'd11;
            state_d  = IDLE;
          end else begin
            acc_d   = acc_sum;
            sub_d   = sub + 2'd1;
            code_d  = 12'h800;
            idx_d   = 4'd11;
            state_d = ENTRY;
          end
`else
          result_d = decided;
          code_d   = decided;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          idx_d    = 4'd11;
          state_d  = IDLE;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign dac_code  = code;
  assign result    = result_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
`timescale 1ns/1ps
module tb_sar_adc_ctrl;

  localparam int S = 1;
`ifdef SAR_OVERSAMPLE_EN
  localparam int LAT = 48 * (S + 1);
`else
  localparam int LAT = 12 * (S + 1);
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [11:0] vin = 12'h000;
  logic        comp_in;
  logic [11:0] dac_code, result;
  logic        valid, busy;
  logic [1:0]  fsm_state;

  // Ideal comparator.
  assign comp_in = (vin >= dac_code);

  sar_adc_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .comp_in   (comp_in),
    .dac_code  (dac_code),
    .result    (result),
    .valid     (valid),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int          cyc_q[$];
  logic [11:0] prev_result = 12'h000;
  logic [11:0] e_res;
  int          e_cyc;

  always @(negedge clk) begin
    if (rst) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(valid), 32'd0);
        end else begin
          e_res = exp_q.pop_front();
          e_cyc = cyc_q.pop_front();
          check("result", 32'(result), 32'(e_res));
          check("latency", 32'(cyc), 32'(e_cyc));
          check("busy_at_valid", 32'(busy), 32'd0);
        end
      end else begin
        check("result_hold", 32'(result), 32'(prev_result));
      end
    end
    prev_result = result;
  end

  // ---------------- driver tasks ----------------
  // Drives a one-cycle start; returns at the negedge after the accepting edge.
  task automatic launch(input logic [11:0] v, input logic [11:0] exp_res);
    @(negedge clk);
    vin   = v;
    start = 1'b1;
    exp_q.push_back(exp_res);
    cyc_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for valid with a cycle budget, checking busy stays high until then.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
      check("busy_run", 32'(busy), 32'd1);
    end
    if (!seen) check("valid_timeout", 32'd0, 32'd1);
  endtask

  logic [11:0] seq[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dac", 32'(dac_code), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst = 1'b1;

    // A5C: trial sequence and result.
    seq[0] = 12'h800; seq[1] = 12'hC00; seq[2] = 12'hA00; seq[3] = 12'hB00; seq[4] = 12'hA80;
    launch(12'hA5C, 12'hA5C);
    check("dac_seq0", 32'(dac_code), 32'(seq[0]));
    check("busy_start", 32'(busy), 32'd1);
    for (int i = 1; i < 5; i++) begin
      repeat (S + 1) @(negedge clk);
      check("dac_seq", 32'(dac_code), 32'(seq[i]));
    end
    wait_done();
    check("dac_hold", 32'(dac_code), 32'hA5C);

    // Boundary codes.
    launch(12'h000, 12'h000); wait_done();
    launch(12'hFFF, 12'hFFF); wait_done();
    launch(12'h800, 12'h800); wait_done();
    repeat (3) @(negedge clk);
    check("idle_state", 32'(fsm_state), 32'd0);

    // Start while busy is ignored.
    launch(12'h123, 12'h123);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (LAT + 5) @(negedge clk);

    // Random codes.
    for (int i = 0; i < 4; i++) begin
      logic [11:0] r;
      r = 12'($urandom_range(0, 4095));
      launch(r, r);
      wait_done();
    end

    // Reset mid-conversion aborts; first start after release is accepted.
    launch(12'h555, 12'h555);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_dac", 32'(dac_code), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(fsm_state), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    repeat (3) @(negedge clk);
    vin   = 12'h3C7;
    start = 1'b1;
    rst   = 1'b1;
    exp_q.push_back(12'h3C7);
    cyc_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    start = 1'b0;
    check("first_after_rst_busy", 32'(busy), 32'd1);
    wait_done();

    // start held high: back-to-back conversions.
    @(negedge clk);
    vin   = 12'h100;
    start = 1'b1;
    exp_q.push_back(12'h100);
    cyc_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    wait_done();
    vin = 12'h200;
    exp_q.push_back(12'h200);
    cyc_q.push_back(cyc + 1 + LAT);
    @(negedge clk);
    wait_done();
    start = 1'b0;

`ifdef SAR_OVERSAMPLE_EN
    // Alternating input per sub-conversion averages to the midpoint.
    launch(12'h100, 12'h102);
    repeat (LAT / 4) @(negedge clk);
    vin = 12'h104;
    repeat (LAT / 4) @(negedge clk);
    vin = 12'h100;
    repeat (LAT / 4) @(negedge clk);
    vin = 12'h104;
    wait_done();
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
